lcd_write_ctrl: RTL and testbench

- Sequences character-LCD bus cycles (HD44780-style, 8-bit parallel, write-only) from single-byte requests issued by the memory-mapped I/O store path to the LCD region.
- Generates RS/RW/DATA setup, the EN pulse, hold, and the post-command execution wait.
- Exposes a busy/status word for the load multiplexer, so software can poll instead of counting delays.

---
 rtl/lcd_write_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_lcd_write_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_ctrl.sv
// lcd_write_ctrl: sequences write-only HD44780-style 8-bit LCD bus cycles.
// One byte per accepted request: RS/DATA setup, EN pulse, hold, then an
// execution wait. The wait is long for clear/home commands and short for
// everything else.
//
// Optional build macro LCD_INIT_EN: after reset the controller waits 750000
// cycles. It then issues the power-on command sequence 0x38, 0x0C, 0x01, 0x06
// by itself, before it accepts any request.
//
// Request handshake (valid/ready):
//   A byte is taken on a rising clk edge where i_req_valid && o_req_ready.
//   o_req_ready is registered and is high only in IDLE. A requester that sees
//   ready low must hold i_req_valid, i_req_rs and i_req_data steady. Nothing is
//   latched while ready is low.
//
// o_dbg_state exposes the FSM state so an external checker can bind to it.
module lcd_write_ctrl #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_CLEAR = 82000,
  parameter int unsigned CNT_W   = 20
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_rs,
  input  logic [7:0]  i_req_data,
  input  logic        i_lcd_on,
  output logic        o_busy,
  output logic [31:0] o_status,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_PULSE     = 3'd2,
    ST_HOLD      = 3'd3,
    ST_WAIT      = 3'd4,
    ST_INIT_WAIT = 3'd5
  } state_t;

  // A zero timing parameter still means one cycle. The state cannot be skipped.
  localparam int unsigned SETUP_N = (T_SETUP == 0) ? 1 : T_SETUP;
  localparam int unsigned PULSE_N = (T_PULSE == 0) ? 1 : T_PULSE;
  localparam int unsigned HOLD_N  = (T_HOLD  == 0) ? 1 : T_HOLD;
  localparam int unsigned EXEC_N  = (T_EXEC  == 0) ? 1 : T_EXEC;
  localparam int unsigned CLEAR_N = (T_CLEAR == 0) ? 1 : T_CLEAR;

  // The counter loads N-1 on entry. The state exits on the edge that sees 0,
  // so the state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_N - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_N - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_N - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_N - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_N - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

`ifdef LCD_INIT_EN
  localparam int unsigned    INIT_N  = 750000;
  localparam logic [CNT_W-1:0] INIT_LD = CNT_W'(INIT_N - 1);

  logic [1:0] init_idx;
  logic       init_active;

  // Power-on command sequence: 8-bit/2-line, display on, clear, entry mode.
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction
`endif

  // Main sequencer: state, delay counter and all registered bus/handshake outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      cnt         <= '0;
      o_lcd_data  <= 8'h00;
      o_lcd_rs    <= 1'b0;
      o_lcd_en    <= 1'b0;
`ifdef LCD_INIT_EN
      state       <= ST_INIT_WAIT;
      cnt         <= INIT_LD;
      o_req_ready <= 1'b0;
      o_busy      <= 1'b1;
      init_idx    <= 2'd0;
      init_active <= 1'b1;
`else
      state       <= ST_IDLE;
      o_req_ready <= 1'b1;
      o_busy      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          o_lcd_en <= 1'b0;
          if (i_req_valid && o_req_ready) begin
            o_lcd_data  <= i_req_data;
            o_lcd_rs    <= i_req_rs;
            o_req_ready <= 1'b0;
            o_busy      <= 1'b1;
            cnt         <= SETUP_LD;
            state       <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (cnt == '0) begin
            o_lcd_en <= 1'b1;
            cnt      <= PULSE_LD;
            state    <= ST_PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_PULSE: begin
          if (cnt == '0) begin
            o_lcd_en <= 1'b0;
            cnt      <= HOLD_LD;
            state    <= ST_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_HOLD: begin
          if (cnt == '0) begin
            cnt   <= is_long_cmd(o_lcd_rs, o_lcd_data) ? CLEAR_LD : EXEC_LD;
            state <= ST_WAIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_WAIT: begin
          if (cnt == '0) begin
`ifdef LCD_INIT_EN
            if (init_active && (init_idx != 2'd3)) begin
              // Chain straight into the next power-on command.
              init_idx   <= init_idx + 2'd1;
              o_lcd_data <= init_byte(init_idx + 2'd1);
              o_lcd_rs   <= 1'b0;
              cnt        <= SETUP_LD;
              state      <= ST_SETUP;
            end else begin
              init_active <= 1'b0;
              o_req_ready <= 1'b1;
              o_busy      <= 1'b0;
              state       <= ST_IDLE;
            end
`else
            o_req_ready <= 1'b1;
            o_busy      <= 1'b0;
            state       <= ST_IDLE;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

`ifdef LCD_INIT_EN
        ST_INIT_WAIT: begin
          if (cnt == '0) begin
            o_lcd_data <= init_byte(2'd0);
            o_lcd_rs   <= 1'b0;
            cnt        <= SETUP_LD;
            state      <= ST_SETUP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif

        default: begin
          o_lcd_en    <= 1'b0;
          o_req_ready <= 1'b1;
          o_busy      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  // LCD power follows the buffer bit with one cycle of latency, whatever the FSM is doing.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_lcd_on <= 1'b0;
    end else begin
      o_lcd_on <= i_lcd_on;
    end
  end

  // Write-only bus. The status word is built purely from registered fields.
  assign o_lcd_rw    = 1'b0;
  assign o_status    = {15'd0, o_lcd_rs, o_lcd_data, 7'd0, o_busy};
  assign o_dbg_state = state;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// tb_lcd_write_ctrl: directed bench for lcd_write_ctrl in the default build.
// T_CLEAR is shortened to 20000 so that the clear/home cases stay short in
// simulation. Expected latencies are computed by hand from the timing values:
//   normal write : 2 + 12 + 2 + 2000  + 1 = 2017
//   clear / home : 2 + 12 + 2 + 20000 + 1 = 20017
// Cycle numbering: cycle 1 is the first cycle after the accept edge. A latency
// of L means o_req_ready reads 1 in cycle L. EN must be high in cycles 3..14.
module tb_lcd_write_ctrl;

  localparam int EXEC_LAT  = 2017;
  localparam int CLEAR_LAT = 20017;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_rs;
  logic [7:0]  req_data;
  logic        lcd_on_in;
  logic        busy;
  logic [31:0] status;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic        lcd_on;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_write_ctrl #(
    .T_SETUP (2),
    .T_PULSE (12),
    .T_HOLD  (2),
    .T_EXEC  (2000),
    .T_CLEAR (20000),
    .CNT_W   (20)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_rs    (req_rs),
    .i_req_data  (req_data),
    .i_lcd_on    (lcd_on_in),
    .o_busy      (busy),
    .o_status    (status),
    .o_lcd_data  (lcd_data),
    .o_lcd_rs    (lcd_rs),
    .o_lcd_rw    (lcd_rw),
    .o_lcd_en    (lcd_en),
    .o_lcd_on    (lcd_on),
    .o_dbg_state (dbg_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one byte and watch the whole transaction. The task is entered at a
  // negedge where ready is expected to be 1, and it returns at the negedge
  // where ready is back at 1. If hold_next is set, a 0x42 data request is
  // raised in cycle 5 and left valid at return.
  task automatic run_write(input string tag, input logic rs, input logic [7:0] d,
                           input int exp_lat, input logic hold_next);
    int c;
    int en_first;
    int en_last;
    int rises;
    int bus_bad;
    int stat_bad;
    logic prev_en;
    logic [31:0] exp_stat;
    exp_stat = {15'd0, rs, d, 7'd0, 1'b1};
    check({tag, "_ready_in"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    c = 1;
    en_first = -1;
    en_last  = -1;
    rises    = 0;
    bus_bad  = 0;
    stat_bad = 0;
    prev_en  = 1'b0;
    while (!req_ready && c < exp_lat + 50) begin
      if (lcd_en) begin
        if (en_first < 0) en_first = c;
        en_last = c;
        if (!prev_en) rises++;
      end
      prev_en = lcd_en;
      if (lcd_data !== d || lcd_rs !== rs || lcd_rw !== 1'b0) bus_bad++;
      if (status !== exp_stat || busy !== 1'b1) stat_bad++;
      if (hold_next && c == 5) begin
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h42;
      end
      @(negedge clk);
      c++;
    end
    check({tag, "_latency"}, c, exp_lat);
    check({tag, "_en_first"}, en_first, 3);
    check({tag, "_en_last"}, en_last, 14);
    check({tag, "_en_pulses"}, rises, 1);
    check({tag, "_bus_stable"}, bus_bad, 0);
    check({tag, "_status_busy"}, stat_bad, 0);
    check({tag, "_status_done"}, status, {15'd0, rs, d, 8'd0});
  endtask

  initial begin
    int en_seen;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_rs    = 1'b0;
    req_data  = 8'h00;
    lcd_on_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // State right after reset: only ready is high.
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_status", status, 32'd0);
    check("rst_data", {24'd0, lcd_data}, 32'd0);
    check("rst_rs", {31'd0, lcd_rs}, 32'd0);
    check("rst_rw", {31'd0, lcd_rw}, 32'd0);
    check("rst_en", {31'd0, lcd_en}, 32'd0);
    check("rst_on", {31'd0, lcd_on}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);

    // LCD power has one cycle of latency.
    lcd_on_in = 1'b1;
    #1;
    check("on_before_edge", {31'd0, lcd_on}, 32'd0);
    @(negedge clk);
    check("on_after_edge", {31'd0, lcd_on}, 32'd1);
    lcd_on_in = 1'b0;
    @(negedge clk);
    check("off_after_edge", {31'd0, lcd_on}, 32'd0);

    // Main transaction cases.
    run_write("data41", 1'b1, 8'h41, EXEC_LAT, 1'b0);
    check("data41_status_word", status, 32'h0001_4100);
    run_write("clr01", 1'b0, 8'h01, CLEAR_LAT, 1'b0);
    run_write("data01", 1'b1, 8'h01, EXEC_LAT, 1'b0);
    run_write("home03", 1'b0, 8'h03, CLEAR_LAT, 1'b0);
    run_write("cmd38", 1'b0, 8'h38, EXEC_LAT, 1'b1);
    // 0x42 has been held valid through the 0x38 transaction. It must be
    // accepted on the edge right after ready rises.
    run_write("b2b42", 1'b1, 8'h42, EXEC_LAT, 1'b0);

    // Reset in the middle of the EN pulse.
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_en_high", {31'd0, lcd_en}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_en", {31'd0, lcd_en}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_data", {24'd0, lcd_data}, 32'd0);
    check("mid_rst_status", status, 32'd0);
    reset_n = 1'b1;
    en_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (lcd_en) en_seen++;
    end
    check("post_rst_no_en", en_seen, 0);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_state", {29'd0, dbg_state}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time limit, set well above the expected run length.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
